// File: rtl/cfg_rr_arbiter_if.sv
// Request/grant bundle between requesters and cfg_rr_arbiter.
// The arbiter connects through the slave modport and the requester side uses the master modport.
interface cfg_rr_arbiter_if #(
  parameter N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [2:0]       gnt_id;
  logic             busy;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy
  );
endinterface

// File: rtl/cfg_rr_arbiter.sv
// Round-robin arbiter with a bounded tenure (HOLD cycles, 0 = unlimited) and registered one-hot grant.
// Optional feature: define CFG_RR_ARBITER_GAP_EN to insert one idle GAP cycle after every release.
module cfg_rr_arbiter #(
  parameter             N_REQ = 4,
  parameter logic [2:0] HOLD  = 3'h4
) (
  input logic              clk,
  input logic              rst_n,
  cfg_rr_arbiter_if.slave  bus
);

`ifdef CFG_RR_ARBITER_GAP_EN
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);

  state_t           state_reg;
  logic [2:0]       ptr_reg;
  logic [2:0]       cnt_reg;
  logic [2:0]       owner_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic             busy_reg;

  logic [2:0]       owner_inc;
  logic             owner_req;
  logic             hold_hit;
  logic             release_now;
  logic [2:0]       base;

  logic [2:0]       cand [N_REQ];
  logic [N_REQ-1:0] sel  [N_REQ];
  logic [N_REQ-1:0] hit;

  logic             found;
  logic [2:0]       pick_idx;
  logic [N_REQ-1:0] pick_oh;

  assign owner_inc   = (owner_reg == 3'(N_REQ - 1)) ? 3'd0 : owner_reg + 3'd1;
  // gnt_reg is the owner's one-hot while in GRANT, so it selects the owner's request bit.
  assign owner_req   = |(bus.req & gnt_reg);
  assign hold_hit    = (HOLD != 3'd0) && (cnt_reg == HOLD - 3'd1);
  assign release_now = (state_reg == GRANT) && (!owner_req || hold_hit);

  // On release the search starts just past the owner, the same place ptr is about to move to.
  assign base = (state_reg == GRANT) ? owner_inc : ptr_reg;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [3:0] sum;
    assign sum      = {1'b0, base} + 4'(gi);
    assign cand[gi] = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
    assign sel[gi]  = ONE_HOT_0 << cand[gi];
    assign hit[gi]  = |(bus.req & sel[gi]);
  end

  // Descending scan so the lowest rotated offset with a request wins.
  always_comb begin
    found    = 1'b0;
    pick_idx = 3'd0;
    pick_oh  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        found    = 1'b1;
        pick_idx = cand[k];
        pick_oh  = sel[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd0;
      cnt_reg   <= 3'd0;
      owner_reg <= 3'd0;
      gnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg <= GRANT;
            gnt_reg   <= pick_oh;
            owner_reg <= pick_idx;
            cnt_reg   <= 3'd0;
            busy_reg  <= 1'b1;
          end
        end

        GRANT: begin
          if (release_now) begin
            ptr_reg <= owner_inc;
`ifdef CFG_RR_ARBITER_GAP_EN
            state_reg <= GAP;
            gnt_reg   <= '0;
            busy_reg  <= 1'b1;
`else
            // A lone owner at HOLD expiry is found again here, so its grant never drops.
            if (found) begin
              gnt_reg   <= pick_oh;
              owner_reg <= pick_idx;
              cnt_reg   <= 3'd0;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end
`endif
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end

`ifdef CFG_RR_ARBITER_GAP_EN
        GAP: begin
          if (found) begin
            state_reg <= GRANT;
            gnt_reg   <= pick_oh;
            owner_reg <= pick_idx;
            cnt_reg   <= 3'd0;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
`endif

        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_reg;
  assign bus.gnt_id = owner_reg;
  assign bus.busy   = busy_reg;

endmodule

// File: tb/tb_cfg_rr_arbiter.sv
// Directed scoreboard bench for cfg_rr_arbiter: HOLD=4, HOLD=3.1415 (->3) and HOLD=9 (->1) instances.
// Expectations follow the GAP timing when CFG_RR_ARBITER_GAP_EN is defined.
module tb_cfg_rr_arbiter;

  typedef struct {
    int         inst;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  localparam int HOLD_PI = int'(3.1415);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_v [3];
  logic [7:0] obs   [3];
  exp_t       sb [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  cfg_rr_arbiter_if #(.N_REQ(4)) bus_a ();
  cfg_rr_arbiter_if #(.N_REQ(4)) bus_b ();
  cfg_rr_arbiter_if #(.N_REQ(4)) bus_c ();

  assign bus_a.req = req_v[0];
  assign bus_b.req = req_v[1];
  assign bus_c.req = req_v[2];
  assign obs[0] = {bus_a.gnt, bus_a.gnt_id, bus_a.busy};
  assign obs[1] = {bus_b.gnt, bus_b.gnt_id, bus_b.busy};
  assign obs[2] = {bus_c.gnt, bus_c.gnt_id, bus_c.busy};

  cfg_rr_arbiter #(.N_REQ(4), .HOLD(3'h4)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  cfg_rr_arbiter #(.N_REQ(4), .HOLD(3'(HOLD_PI))) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  cfg_rr_arbiter #(.N_REQ(4), .HOLD(3'(9))) dut_c (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_c)
  );

  task automatic check_front();
    exp_t x;
    x = sb.pop_front();
    checks++;
    assert (obs[x.inst] === x.exp) else begin
      errors++;
      $error("FAIL %s inst=%0d gnt/id/busy observed=%b/%0d/%b expected=%b/%0d/%b",
             x.tag, x.inst, obs[x.inst][7:4], obs[x.inst][3:1], obs[x.inst][0],
             x.exp[7:4], x.exp[3:1], x.exp[0]);
    end
    $display("t=%0t inst=%0d %s req=%b gnt=%b id=%0d busy=%b", $time, x.inst, x.tag,
             req_v[x.inst], obs[x.inst][7:4], obs[x.inst][3:1], obs[x.inst][0]);
  endtask

  task automatic step(input int inst, input logic [3:0] r, input logic [7:0] e, input string tag);
    req_v[inst] = r;
    sb.push_back('{inst: inst, exp: e, tag: tag});
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic do_reset(input logic [3:0] r, input string tag);
    for (int i = 0; i < 3; i++) req_v[i] = r;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{inst: i, exp: 8'h00, tag: {tag, "_async"}});
      check_front();
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{inst: i, exp: 8'h00, tag: {tag, "_held"}});
      check_front();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) req_v[i] = 4'b0000;
  endtask

  task automatic run_tenures(input int inst, input logic [3:0] r, input int hold, input int n,
                             input int owners [8], input string tag);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < hold; c++)
        step(inst, r, {4'(1 << owners[i]), 3'(owners[i]), 1'b1}, tag);
`ifdef CFG_RR_ARBITER_GAP_EN
      if (i != n - 1)
        step(inst, r, {4'b0000, 3'(owners[i]), 1'b1}, {tag, "_gap"});
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) req_v[i] = 4'b0000;

    // Reset with all requests high, then idle with no requests.
    do_reset(4'b1111, "reset_req_all");
    for (int i = 0; i < 5; i++) step(0, 4'b0000, 8'h00, "idle_no_req");

    // Full rotation with everyone requesting.
    run_tenures(0, 4'b1111, 4, 5, '{0, 1, 2, 3, 0, 0, 0, 0}, "rr_all");

    // Single requester keeps its grant across HOLD expiry.
    do_reset(4'b0000, "reset2");
    run_tenures(0, 4'b0001, 4, 3, '{0, 0, 0, 0, 0, 0, 0, 0}, "solo_regrant");

    // HOLD truncation: 3.1415 -> 3 cycles, 9 -> 1 cycle.
    do_reset(4'b0000, "reset3");
    run_tenures(1, 4'b0011, 3, 4, '{0, 1, 0, 1, 0, 0, 0, 0}, "hold_pi");
    req_v[1] = 4'b0000;
    do_reset(4'b0000, "reset4");
    run_tenures(2, 4'b0011, 1, 6, '{0, 1, 0, 1, 0, 1, 0, 0}, "hold_9");

    // No preemption by lower-index requests arriving mid-tenure.
    do_reset(4'b0000, "reset5");
    step(0, 4'b0100, {4'b0100, 3'd2, 1'b1}, "nopreempt_first");
    for (int i = 0; i < 3; i++) step(0, 4'b0111, {4'b0100, 3'd2, 1'b1}, "nopreempt_hold");
`ifdef CFG_RR_ARBITER_GAP_EN
    step(0, 4'b0111, {4'b0000, 3'd2, 1'b1}, "nopreempt_gap");
`endif
    step(0, 4'b0111, {4'b0001, 3'd0, 1'b1}, "nopreempt_next");

    // Owner drops early with req[2] pending; then release to idle.
    do_reset(4'b0000, "reset6");
    step(0, 4'b0101, {4'b0001, 3'd0, 1'b1}, "drop_own_c1");
    step(0, 4'b0101, {4'b0001, 3'd0, 1'b1}, "drop_own_c2");
`ifdef CFG_RR_ARBITER_GAP_EN
    step(0, 4'b0100, {4'b0000, 3'd0, 1'b1}, "drop_gap");
`endif
    step(0, 4'b0100, {4'b0100, 3'd2, 1'b1}, "drop_move");
    step(0, 4'b0100, {4'b0100, 3'd2, 1'b1}, "drop_keep");
`ifdef CFG_RR_ARBITER_GAP_EN
    step(0, 4'b0000, {4'b0000, 3'd2, 1'b1}, "to_idle_gap");
`endif
    step(0, 4'b0000, {4'b0000, 3'd2, 1'b0}, "to_idle");

    // Mid-tenure reset: pointer returns to 0.
    step(0, 4'b0100, {4'b0100, 3'd2, 1'b1}, "pre_rst_grant");
    do_reset(4'b1101, "rst_mid");
    step(0, 4'b1101, {4'b0001, 3'd0, 1'b1}, "post_rst_ptr0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
